// File: rtl/ahb_pkg.sv
// Shared AHB decoder definitions: region map, transfer encodings and
// default-slave state enumeration.
package ahb_pkg;

  localparam logic [7:0] FIRST_REGION = 8'h01;
  localparam logic [7:0] LAST_REGION  = 8'h10;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    DEF_IDLE = 2'b00,
    DEF_ERR1 = 2'b01,
    DEF_ERR2 = 2'b10
  } def_state_t;

  function automatic logic region_mapped(input logic [7:0] code);
    return (code >= FIRST_REGION) && (code <= LAST_REGION);
  endfunction

  function automatic logic trans_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_decoder_if.sv
// Bus-side signals of the AHB address decoder and its default slave.
interface ahb_decoder_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] HADDR;
  logic [1:0]       HTRANS;
  logic             HREADY;
  logic             HREADYOUT_MUX;
  logic             HRESP_MUX;
  logic [15:0]      HSEL;
  logic [7:0]       MUX_SEL;
  logic             DEF_SEL;
  logic             HREADYOUT_DEF;
  logic             HRESP_DEF;
  logic [15:0]      ERR_COUNT;
  logic             HREADY_BUS;
  logic             HRESP_BUS;

  modport slave (
    input  HADDR, HTRANS, HREADY, HREADYOUT_MUX, HRESP_MUX,
    output HSEL, MUX_SEL, DEF_SEL, HREADYOUT_DEF, HRESP_DEF, ERR_COUNT,
           HREADY_BUS, HRESP_BUS
  );

  modport master (
    output HADDR, HTRANS, HREADY, HREADYOUT_MUX, HRESP_MUX,
    input  HSEL, MUX_SEL, DEF_SEL, HREADYOUT_DEF, HRESP_DEF, ERR_COUNT,
           HREADY_BUS, HRESP_BUS
  );
endinterface

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR response for active transfers to unmapped
// addresses, plus a saturating count of issued ERROR responses.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic        addr_mapped,
  output logic        HREADYOUT_DEF,
  output logic        HRESP_DEF,
  output logic [15:0] ERR_COUNT
);

  def_state_t  state_q;
  def_state_t  state_d;
  logic [15:0] err_count_q;
  logic        err_req;

  assign err_req   = HREADY && trans_active(HTRANS) && !addr_mapped;
  assign ERR_COUNT = err_count_q;

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= DEF_IDLE;
    else        state_q <= state_d;
  end

  // Next state and response outputs
  always_comb begin
    state_d       = state_q;
    HREADYOUT_DEF = 1'b1;
    HRESP_DEF     = 1'b0;
    case (state_q)
      DEF_IDLE: begin
        if (err_req) state_d = DEF_ERR1;
      end
      DEF_ERR1: begin
        HREADYOUT_DEF = 1'b0;
        HRESP_DEF     = 1'b1;
        state_d       = DEF_ERR2;
      end
      DEF_ERR2: begin
        HRESP_DEF = 1'b1;
        state_d   = err_req ? DEF_ERR1 : DEF_IDLE;
      end
      default: state_d = DEF_IDLE;
    endcase
  end

  // Count each completed first ERROR cycle, saturating at all-ones
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      err_count_q <= '0;
    end else if (state_q == DEF_ERR1 && err_count_q != '1) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

endmodule

// File: rtl/ahb_decoder.sv
// AHB address decoder: combinational slave selects, data-phase response
// source register and the internal default slave.
module ahb_decoder
  import ahb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic HCLK,
  input  logic HRESET,
  ahb_decoder_if.slave bus
);

  logic [WIDTH-1:0] haddr;
  logic [7:0]       code;
  logic             mapped;
  logic [7:0]       mux_sel_q;
  logic             def_sel_q;
  logic             unused_addr_bits;

  assign haddr            = bus.HADDR;
  assign code             = haddr[31:24];
  assign unused_addr_bits = ^haddr[23:0];
  assign mapped           = region_mapped(code);

  // One-hot slave select from the region code alone
  always_comb begin
    bus.HSEL = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      bus.HSEL[i] = mapped && (code == FIRST_REGION + 8'(i));
    end
  end

  // Data-phase response source; held while the bus is wait-stated
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      mux_sel_q <= FIRST_REGION;
      def_sel_q <= 1'b1;
    end else if (bus.HREADY) begin
      if (mapped) begin
        mux_sel_q <= code;
        def_sel_q <= 1'b0;
      end else begin
        def_sel_q <= 1'b1;
      end
    end
  end

  assign bus.MUX_SEL = mux_sel_q;
  assign bus.DEF_SEL = def_sel_q;

  ahb_default_slave u_def (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .HREADY        (bus.HREADY),
    .HTRANS        (bus.HTRANS),
    .addr_mapped   (mapped),
    .HREADYOUT_DEF (bus.HREADYOUT_DEF),
    .HRESP_DEF     (bus.HRESP_DEF),
    .ERR_COUNT     (bus.ERR_COUNT)
  );

  // Bus response: default slave owns the data phase when DEF_SEL is set
  always_comb begin
    bus.HREADY_BUS = bus.HREADYOUT_MUX;
    bus.HRESP_BUS  = bus.HRESP_MUX;
    if (def_sel_q) begin
      bus.HREADY_BUS = bus.HREADYOUT_DEF;
      bus.HRESP_BUS  = bus.HRESP_DEF;
    end
  end

endmodule

// File: tb/tb_ahb_decoder.sv
// Self-checking bench for ahb_decoder against a transfer-level model.
module tb_ahb_decoder;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  ahb_decoder_if #(.WIDTH(32)) bus ();
  ahb_decoder #(.WIDTH(32)) dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Model: response source, cycles left in an ERROR response, error tally
  int   m_mux;
  bit   m_def;
  int   m_err_left;
  int   m_cnt;

  logic [15:0] s_hsel, e_hsel;
  logic        s_rdy, e_rdy, s_resp, e_resp;

  function automatic logic [15:0] ref_hsel(input logic [31:0] a);
    int c;
    c = int'(a[31:24]);
    if (c >= 1 && c <= 16) return 16'(1 << (c - 1));
    return 16'h0000;
  endfunction

  task automatic reset_model();
    m_mux = 1; m_def = 1; m_err_left = 0; m_cnt = 0;
  endtask

  // Drive one cycle; HREADY is what the bus fabric would present
  task automatic step(input logic [31:0] addr, input logic [1:0] trans,
                      input logic mrdy, input logic mresp);
    int   c;
    logic hr;
    c  = int'(addr[31:24]);
    hr = m_def ? (m_err_left != 2) : mrdy;
    bus.HADDR = addr; bus.HTRANS = trans; bus.HREADY = hr;
    bus.HREADYOUT_MUX = mrdy; bus.HRESP_MUX = mresp;
    e_hsel = ref_hsel(addr);
    e_rdy  = hr;
    e_resp = m_def ? (m_err_left != 0) : mresp;
    #1;
    s_hsel = bus.HSEL; s_rdy = bus.HREADY_BUS; s_resp = bus.HRESP_BUS;
    @(posedge HCLK);
    if (m_err_left == 2) begin
      m_err_left = 1;
      if (m_cnt < 65535) m_cnt++;
    end else if (hr && trans[1] && (c < 1 || c > 16)) begin
      m_err_left = 2;
    end else begin
      m_err_left = 0;
    end
    if (hr) begin
      if (c >= 1 && c <= 16) begin m_mux = c; m_def = 0; end
      else m_def = 1;
    end
    @(negedge HCLK);
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    #2;
    HRESET = 1'b0;
    reset_model();
    @(negedge HCLK);
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    bus.HADDR = 32'h0; bus.HTRANS = T_IDLE; bus.HREADY = 1'b1;
    bus.HREADYOUT_MUX = 1'b0; bus.HRESP_MUX = 1'b1;
    #3;
    checks++; if (bus.MUX_SEL !== 8'h01) begin errors++; $display("FAIL reset_mux got %h exp 01", bus.MUX_SEL); end
    checks++; if (bus.DEF_SEL !== 1'b1) begin errors++; $display("FAIL reset_def got %b exp 1", bus.DEF_SEL); end
    checks++; if (bus.HREADYOUT_DEF !== 1'b1 || bus.HRESP_DEF !== 1'b0) begin errors++; $display("FAIL reset_resp got %b/%b exp 1/0", bus.HREADYOUT_DEF, bus.HRESP_DEF); end
    checks++; if (bus.ERR_COUNT !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0000", bus.ERR_COUNT); end
    @(negedge HCLK);
    HRESET = 1'b0;
    reset_model();
    step(32'h0000_0000, T_IDLE, 1'b0, 1'b1);
    checks++; if (s_rdy !== 1'b1 || s_resp !== 1'b0) begin errors++; $display("FAIL first_ready got %b/%b exp 1/0", s_rdy, s_resp); end
  endtask

  task automatic test_map();
    logic [31:0] a;
    step(32'h0500_0000, T_NSEQ, 1'b1, 1'b0);
    checks++; if (s_hsel !== 16'h0010) begin errors++; $display("FAIL map_hsel got %h exp 0010", s_hsel); end
    checks++; if (bus.MUX_SEL !== 8'h05 || bus.DEF_SEL !== 1'b0) begin errors++; $display("FAIL map_phase got %h/%b exp 05/0", bus.MUX_SEL, bus.DEF_SEL); end
    for (int c = 0; c < 20; c++) begin
      a = {8'(c == 19 ? 255 : c), 24'($urandom)};
      step(a, (c % 2 == 0) ? T_IDLE : T_BUSY, 1'b1, 1'b0);
      checks++; if (s_hsel !== e_hsel) begin errors++; $display("FAIL map_code%0d got %h exp %h", c, s_hsel, e_hsel); end
      checks++; if (bus.MUX_SEL !== 8'(m_mux) || bus.DEF_SEL !== m_def) begin errors++; $display("FAIL map_reg%0d got %h/%b exp %h/%b", c, bus.MUX_SEL, bus.DEF_SEL, 8'(m_mux), m_def); end
      checks++; if (bus.HREADYOUT_DEF !== 1'b1 || bus.HRESP_DEF !== 1'b0) begin errors++; $display("FAIL unmapped_idle%0d got %b/%b exp 1/0", c, bus.HREADYOUT_DEF, bus.HRESP_DEF); end
    end
  endtask

  task automatic test_error();
    do_reset();
    step(32'h2000_0000, T_NSEQ, 1'b1, 1'b0);
    checks++; if (bus.HREADYOUT_DEF !== 1'b0 || bus.HRESP_DEF !== 1'b1) begin errors++; $display("FAIL err1 got %b/%b exp 0/1", bus.HREADYOUT_DEF, bus.HRESP_DEF); end
    step(32'h2000_0000, T_IDLE, 1'b1, 1'b0);
    checks++; if (s_rdy !== 1'b0 || s_resp !== 1'b1) begin errors++; $display("FAIL err1_bus got %b/%b exp 0/1", s_rdy, s_resp); end
    checks++; if (bus.HREADYOUT_DEF !== 1'b1 || bus.HRESP_DEF !== 1'b1) begin errors++; $display("FAIL err2 got %b/%b exp 1/1", bus.HREADYOUT_DEF, bus.HRESP_DEF); end
    step(32'h2000_0000, T_IDLE, 1'b1, 1'b0);
    checks++; if (bus.HREADYOUT_DEF !== 1'b1 || bus.HRESP_DEF !== 1'b0) begin errors++; $display("FAIL err_done got %b/%b exp 1/0", bus.HREADYOUT_DEF, bus.HRESP_DEF); end
    checks++; if (bus.ERR_COUNT !== 16'd1) begin errors++; $display("FAIL err_cnt got %h exp 0001", bus.ERR_COUNT); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_r [5] = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b10};
    logic [31:0] addr_s [5] = '{32'h2000_0000, 32'h0, 32'h8000_0000, 32'h0, 32'h0};
    logic [1:0] tr_s [5] = '{T_NSEQ, T_IDLE, T_SEQ, T_IDLE, T_IDLE};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(addr_s[i], tr_s[i], 1'b1, 1'b0);
      checks++; if ({bus.HREADYOUT_DEF, bus.HRESP_DEF} !== exp_r[i]) begin errors++; $display("FAIL b2b%0d got %b exp %b", i, {bus.HREADYOUT_DEF, bus.HRESP_DEF}, exp_r[i]); end
    end
    checks++; if (bus.ERR_COUNT !== 16'd2) begin errors++; $display("FAIL b2b_cnt got %h exp 0002", bus.ERR_COUNT); end
    step(32'hFF00_0000, T_NSEQ, 1'b1, 1'b0);
    step(32'h0, T_IDLE, 1'b1, 1'b0);
    step(32'h0A00_0000, T_NSEQ, 1'b1, 1'b0);
    checks++; if ({bus.HREADYOUT_DEF, bus.HRESP_DEF, bus.DEF_SEL, bus.MUX_SEL} !== {3'b100, 8'h0A}) begin errors++; $display("FAIL err2_mapped got %b%b%b/%h exp 100/0a", bus.HREADYOUT_DEF, bus.HRESP_DEF, bus.DEF_SEL, bus.MUX_SEL); end
  endtask

  task automatic test_wait_hold();
    step(32'h0300_0000, T_NSEQ, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(32'h0700_0000, T_NSEQ, 1'b0, 1'b0);
      checks++; if (bus.MUX_SEL !== 8'h03 || bus.DEF_SEL !== 1'b0) begin errors++; $display("FAIL wait_hold%0d got %h/%b exp 03/0", i, bus.MUX_SEL, bus.DEF_SEL); end
    end
    step(32'h0700_0000, T_NSEQ, 1'b1, 1'b0);
    checks++; if (bus.MUX_SEL !== 8'h07) begin errors++; $display("FAIL wait_release got %h exp 07", bus.MUX_SEL); end
    step(32'hF000_0000, T_NSEQ, 1'b0, 1'b0);
    checks++; if (bus.DEF_SEL !== 1'b0 || bus.HREADYOUT_DEF !== 1'b1) begin errors++; $display("FAIL wait_unmapped got %b/%b exp 0/1", bus.DEF_SEL, bus.HREADYOUT_DEF); end
  endtask

  task automatic test_reset_mid_error();
    step(32'h4400_0000, T_NSEQ, 1'b1, 1'b0);
    #2 HRESET = 1'b1;
    #1;
    checks++; if ({bus.HREADYOUT_DEF, bus.HRESP_DEF, bus.DEF_SEL, bus.MUX_SEL, bus.ERR_COUNT} !== {3'b101, 8'h01, 16'h0}) begin
      errors++; $display("FAIL async_reset got %b%b%b/%h/%h exp 101/01/0000", bus.HREADYOUT_DEF, bus.HRESP_DEF, bus.DEF_SEL, bus.MUX_SEL, bus.ERR_COUNT);
    end
    @(negedge HCLK);
    HRESET = 1'b0;
    reset_model();
    step(32'h0, T_IDLE, 1'b1, 1'b0);
    checks++; if (bus.HREADYOUT_DEF !== 1'b1 || bus.HRESP_DEF !== 1'b0) begin errors++; $display("FAIL no_resume got %b/%b exp 1/0", bus.HREADYOUT_DEF, bus.HRESP_DEF); end
  endtask

  task automatic test_saturate();
    force dut.u_def.err_count_q = 16'hFFFE;
    #1;
    release dut.u_def.err_count_q;
    m_cnt = 65534;
    checks++; if (bus.ERR_COUNT !== 16'hFFFE) begin errors++; $display("FAIL preload got %h exp fffe", bus.ERR_COUNT); end
    for (int i = 0; i < 3; i++) begin
      step(32'h9900_0000, T_NSEQ, 1'b1, 1'b0);
      step(32'h0, T_IDLE, 1'b1, 1'b0);
      step(32'h0, T_IDLE, 1'b1, 1'b0);
      checks++; if (bus.ERR_COUNT !== 16'(m_cnt)) begin errors++; $display("FAIL sat%0d got %h exp %h", i, bus.ERR_COUNT, 16'(m_cnt)); end
    end
    checks++; if (bus.ERR_COUNT !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", bus.ERR_COUNT); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          c;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 18));
      a = {8'(c), 24'($urandom)};
      step(a, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      checks++; if (s_hsel !== e_hsel) begin errors++; $display("FAIL rnd_hsel%0d got %h exp %h", i, s_hsel, e_hsel); end
      checks++; if (s_rdy !== e_rdy || s_resp !== e_resp) begin errors++; $display("FAIL rnd_bus%0d got %b/%b exp %b/%b", i, s_rdy, s_resp, e_rdy, e_resp); end
      checks++; if (bus.MUX_SEL !== 8'(m_mux) || bus.DEF_SEL !== m_def) begin errors++; $display("FAIL rnd_reg%0d got %h/%b exp %h/%b", i, bus.MUX_SEL, bus.DEF_SEL, 8'(m_mux), m_def); end
      checks++; if (bus.HREADYOUT_DEF !== (m_err_left != 2) || bus.HRESP_DEF !== (m_err_left != 0)) begin errors++; $display("FAIL rnd_def%0d got %b/%b exp %b/%b", i, bus.HREADYOUT_DEF, bus.HRESP_DEF, m_err_left != 2, m_err_left != 0); end
      checks++; if (bus.ERR_COUNT !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_cnt%0d got %h exp %h", i, bus.ERR_COUNT, 16'(m_cnt)); end
    end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_map();
    test_error();
    test_back_to_back();
    test_wait_hold();
    test_reset_mid_error();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_decoder.md
AHB_DECODER -- requirements
Module: ahb_decoder

Interface
REQ-001 Parameter: WIDTH, default 32, HADDR bus width; decode uses HADDR[31:24].
REQ-002 HCLK  in  1  single clock for the block; all state changes on its rising edge.
REQ-003 HRESET  in  1  asynchronous, active-high reset.
REQ-004 HADDR  in  WIDTH  address-phase address from the master.
REQ-005 HTRANS  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-006 HREADY  in  1  global bus ready, the output of the response multiplexer.
REQ-007 HSEL  out  16  combinational slave selects; bit i selects slave i+1.
REQ-008 MUX_SEL  out  8  registered data-phase region code; drives the response multiplexer select.
REQ-009 DEF_SEL  out  1  registered flag: the current data phase belongs to the internal default slave.
REQ-010 HREADYOUT_DEF  out  1  default-slave ready.
REQ-011 HRESP_DEF  out  1  default-slave response: 0 OKAY, 1 ERROR.
REQ-012 ERR_COUNT  out  16  saturating count of ERROR responses issued.

Function
REQ-013 Mapped regions are HADDR[31:24] = 8'h01..8'h10; region r shall assert HSEL[r-1] only; every other code asserts no HSEL bit.
REQ-014 HSEL shall be combinational from HADDR, independent of HTRANS and HREADY; slaves qualify selection with HTRANS and HREADY themselves.
REQ-015 When HREADY=1, MUX_SEL and DEF_SEL shall be loaded on the next edge: a mapped code loads MUX_SEL=code and DEF_SEL=0; an unmapped code leaves MUX_SEL unchanged and sets DEF_SEL=1.
REQ-016 When HREADY=0, MUX_SEL and DEF_SEL shall hold; a wait-stated data phase never switches the response source.
REQ-017 The default slave FSM shall have three states: IDLE, ERR1, ERR2.
REQ-018 In IDLE: HREADYOUT_DEF=1 and HRESP_DEF=0. IDLE->ERR1 when HREADY=1, HTRANS is NONSEQ or SEQ, and the address is unmapped.
REQ-019 In ERR1: HREADYOUT_DEF=0 and HRESP_DEF=1. ERR1->ERR2 unconditionally on the next edge.
REQ-020 In ERR2: HREADYOUT_DEF=1 and HRESP_DEF=1, which completes the two-cycle AHB ERROR response.
REQ-021 ERR2->ERR1 when a new unmapped NONSEQ/SEQ transfer is sampled in that cycle (HREADY is 1 in ERR2); otherwise ERR2->IDLE.
REQ-022 IDLE or BUSY transfers to unmapped addresses shall receive a zero-wait OKAY with no FSM transition.
REQ-023 ERR_COUNT shall increment by 1 on every ERR1->ERR2 transition and saturate at 16'hFFFF with no wrap-around.
REQ-024 A mapped transfer sampled in ERR2 shall set DEF_SEL=0 and send the FSM to IDLE on the same edge.

Reset
REQ-025 While HRESET=1, regardless of HCLK, outputs shall be: MUX_SEL=8'h01, DEF_SEL=1, FSM=IDLE (HREADYOUT_DEF=1, HRESP_DEF=0), ERR_COUNT=0.
REQ-026 Reset asserted mid-ERROR (ERR1 or ERR2) shall abort the response immediately to the REQ-025 values; no partial response resumes after reset.
REQ-027 DEF_SEL=1 at reset shall guarantee HREADY=1 on the bus during the first cycle after reset is released.

Structure
REQ-028 The region codes (FIRST_REGION=8'h01, LAST_REGION=8'h10), the HTRANS encodings and the default-slave state enumeration shall live in a shared package, ahb_pkg.
REQ-029 The default slave shall be a single sub-module, ahb_default_slave, containing the FSM and ERR_COUNT; the address decode and the data-phase register shall stay in ahb_decoder.
REQ-030 The top level shall take bus HREADY/HRESP from HREADYOUT_DEF/HRESP_DEF when DEF_SEL=1, and otherwise from the multiplexer.

Verification
REQ-031 HADDR=32'h0500_0000, HTRANS=NONSEQ, HREADY=1 -> HSEL=16'h0010 in the same cycle; MUX_SEL=8'h05 and DEF_SEL=0 after the edge.
REQ-032 HADDR=32'h2000_0000, NONSEQ, HREADY=1 -> next cycle HREADYOUT_DEF=0/HRESP_DEF=1, then 1/1, then 1/0; ERR_COUNT=1.
REQ-033 Back-to-back unmapped NONSEQ transfers with the second sampled in ERR2 -> states ERR1, ERR2, ERR1, ERR2; ERR_COUNT=2.
REQ-034 HREADY=0 for 3 cycles after mapping to 8'h03 while HADDR changes to 8'h07 -> MUX_SEL stays 8'h03 until the first HREADY=1 edge.
REQ-035 HRESET pulsed during ERR1 -> HREADYOUT_DEF=1, HRESP_DEF=0, DEF_SEL=1, MUX_SEL=8'h01, ERR_COUNT=0 asynchronously.
REQ-036 ERR_COUNT preloaded near 16'hFFFF, then 2 error transfers -> ERR_COUNT holds 16'hFFFF.
